stepper_ctrl: RTL and testbench

STEPPER_CTRL -- requirements
Module: stepper_ctrl

---
 rtl/stepper_ctrl.sv | 142 ++++++++++++++
 tb/tb_stepper_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stepper_ctrl.sv
// Memory-mapped stepper motor controller: a 4-word register window sets the step period,
// starts and aborts moves, and reports status, while the controller drives the two coil pairs.
module stepper_ctrl #(
    parameter logic [11:0] BASE_ADDR  = 12'hF00,
    parameter int          PERIOD_MIN = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address,
    input  logic [31:0] data,
    output logic [31:0] q,
    output logic [3:0]  phase,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] PMIN = 16'(PERIOD_MIN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [15:0] period, remaining, timer, position;
    logic [1:0]  idx;
    logic        dir, enable;
    logic [11:0] offset;
    logic        wr_period, wr_move, wr_ctrl;
    logic        start, abort, step, finish;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign offset      = address - BASE_ADDR;
    assign wr_period   = wren && (offset == 12'd0);
    assign wr_move     = wren && (offset == 12'd1);
    assign wr_ctrl     = wren && (offset == 12'd2);
    assign busy        = (state == RUN);
    assign unused_bits = ^data[30:16];

    // An abort from a CTRL write takes priority over any step due in the same cycle.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_move && enable && (data[15:0] != 16'd0)) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (wr_ctrl && !data[0]) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (timer == 16'd1) begin
                    step = 1'b1;
                    if (remaining == 16'd1) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The reload reads the period register as it stands, so a period written mid-move
    // only takes effect at the next reload.
    always_ff @(posedge clock) begin
        if (reset) begin
            period    <= PMIN;
            remaining <= 16'd0;
            timer     <= 16'd0;
            dir       <= 1'b0;
            enable    <= 1'b0;
            idx       <= 2'd0;
            position  <= 16'd0;
            done      <= 1'b0;
            q         <= 32'd0;
        end else begin
            done <= finish;
            q    <= rd_data;
            if (wr_period) begin
                period <= (data[15:0] < PMIN) ? PMIN : data[15:0];
            end
            if (wr_ctrl) begin
                enable <= data[0];
            end
            if (start) begin
                remaining <= data[15:0];
                dir       <= data[31];
                timer     <= period;
            end else if (abort) begin
                remaining <= 16'd0;
            end else if (state == RUN) begin
                if (step) begin
                    timer     <= period;
                    remaining <= remaining - 16'd1;
                    idx       <= dir ? idx - 2'd1 : idx + 2'd1;
                    position  <= dir ? position - 16'd1 : position + 16'd1;
                end else begin
                    timer <= timer - 16'd1;
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (offset)
            12'd0:   rd_data = {16'd0, period};
            12'd1:   rd_data = {16'd0, remaining};
            12'd2:   rd_data = {29'd0, busy, dir, enable};
            12'd3:   rd_data = {{16{position[15]}}, position};
            default: rd_data = 32'd0;
        endcase
    end

    always_comb begin
        phase = 4'b0000;
        if (enable) begin
            case (idx)
                2'd0: phase = 4'b1010;
                2'd1: phase = 4'b0110;
                2'd2: phase = 4'b0101;
                2'd3: phase = 4'b1001;
                default: phase = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Self-checking bench for stepper_ctrl: directed scenarios then random register traffic,
// every cycle compared against a deadline-based behavioural model.
module tb_stepper_ctrl;

    localparam logic [11:0] BASE = 12'hF00;

    logic        clock;
    logic        reset;
    logic        wren;
    logic [11:0] address;
    logic [31:0] data;
    logic [31:0] q;
    logic [3:0]  phase;
    logic        busy;
    logic        done;

    int checks_total;
    int checks_passed;

    logic [15:0] m_period, m_rem, m_pos;
    int          m_idx;
    bit          m_dir, m_en, m_run, m_done;
    logic [31:0] m_q;
    longint      cyc, next_at;
    logic [3:0]  phase_table [4];

    stepper_ctrl #(.BASE_ADDR(BASE), .PERIOD_MIN(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .wren    (wren),
        .address (address),
        .data    (data),
        .q       (q),
        .phase   (phase),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, observed, expected);
        end
    endtask

    // Model: a move is a count of steps scheduled at absolute cycle deadlines.
    task automatic modelEdge(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        logic [11:0] off;
        logic [31:0] newq;
        bit wp, wm, wc;
        off  = a - BASE;
        case (off)
            12'd0:   newq = {16'd0, m_period};
            12'd1:   newq = {16'd0, m_rem};
            12'd2:   newq = {29'd0, m_run, m_dir, m_en};
            12'd3:   newq = {{16{m_pos[15]}}, m_pos};
            default: newq = 32'd0;
        endcase
        if (r) begin
            m_period = 16'd16; m_rem = 16'd0; m_pos = 16'd0; m_idx = 0;
            m_dir = 0; m_en = 0; m_run = 0; m_done = 0; m_q = 32'd0;
        end else begin
            wp = w && (off == 12'd0);
            wm = w && (off == 12'd1);
            wc = w && (off == 12'd2);
            m_done = 0;
            if (m_run) begin
                if (wc && !d[0]) begin
                    m_run = 0;
                    m_rem = 16'd0;
                end else if (cyc == next_at) begin
                    m_idx   = (m_idx + (m_dir ? 3 : 1)) % 4;
                    m_pos   = m_dir ? m_pos - 16'd1 : m_pos + 16'd1;
                    m_rem   = m_rem - 16'd1;
                    next_at = cyc + m_period;
                    if (m_rem == 16'd0) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end else if (wm && m_en && d[15:0] != 16'd0) begin
                m_run   = 1;
                m_rem   = d[15:0];
                m_dir   = d[31];
                next_at = cyc + m_period;
            end
            if (wp) m_period = (d[15:0] < 16'd16) ? 16'd16 : d[15:0];
            if (wc) m_en = d[0];
            m_q = newq;
        end
        cyc++;
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        reset   = r;
        wren    = w;
        address = a;
        data    = d;
        @(posedge clock);
        modelEdge(r, w, a, d);
        #1;
        checkOutput("q", q, m_q);
        checkOutput("phase", {28'd0, phase}, {28'd0, (m_en ? phase_table[m_idx] : 4'b0000)});
        checkOutput("busy", {31'd0, busy}, {31'd0, m_run});
        checkOutput("done", {31'd0, done}, {31'd0, m_done});
    endtask

    task automatic writeReg(input int off, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, BASE + 12'(off), d);
    endtask

    task automatic idleRead(input int n, input int off);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, BASE + 12'(off), 32'hDEAD_BEEF);
    endtask

    initial begin
        int sel;
        logic [31:0] rd;
        checks_total  = 0;
        checks_passed = 0;
        cyc = 0;
        next_at = 0;
        phase_table[0] = 4'b1010;
        phase_table[1] = 4'b0110;
        phase_table[2] = 4'b0101;
        phase_table[3] = 4'b1001;
        reset = 1'b1; wren = 1'b0; address = 12'd0; data = 32'd0;

        applyStimulus(1'b1, 1'b0, BASE, 32'd0);
        applyStimulus(1'b1, 1'b0, BASE, 32'd0);
        for (int i = 0; i < 5; i++) idleRead(1, i);

        writeReg(2, 32'd1);
        writeReg(0, 32'd20);
        writeReg(1, 32'd3);
        idleRead(70, 1);
        idleRead(2, 3);
        idleRead(1, 2);

        for (int i = 0; i < 4; i++) begin
            writeReg(1, 32'h8000_0002);
            idleRead(40, 3);
        end

        writeReg(0, 32'd5);
        idleRead(2, 0);
        writeReg(1, 32'd0);
        idleRead(3, 2);

        writeReg(1, 32'd4);
        idleRead(25, 1);
        writeReg(2, 32'd0);
        writeReg(1, 32'd4);
        idleRead(5, 2);
        idleRead(1, 3);

        writeReg(2, 32'd1);
        writeReg(1, 32'd4);
        idleRead(20, 1);
        applyStimulus(1'b1, 1'b1, BASE + 12'd1, 32'd4);
        idleRead(4, 2);

        writeReg(2, 32'd1);
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 199);
            if (sel == 0) begin
                applyStimulus(1'b1, 1'b0, BASE, 32'd0);
            end else if (sel < 5) begin
                rd = {$urandom, $urandom_range(0, 40)} & 32'h0000_FFFF;
                writeReg(0, rd);
            end else if (sel < 10) begin
                rd = {$urandom_range(0, 1) == 1, 15'd0, 16'($urandom_range(0, 6))};
                writeReg(1, rd);
            end else if (sel < 12) begin
                writeReg(2, {31'd0, ($urandom_range(0, 99) < 85)});
            end else if (sel < 14) begin
                applyStimulus(1'b0, 1'b1, 12'($urandom_range(0, 4095)), $urandom);
            end else begin
                applyStimulus(1'b0, 1'b0, BASE + 12'($urandom_range(0, 5)), $urandom);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
